mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: the multicycle CPU (read/write) and a debug reader (read-only) used by the LCD and switch inspection logic.
- Sits between the requesters and the memory block.
- Sequences every access as ISSUE then DATA, with a req/gnt/rvalid handshake.
- CPU has priority; an optional anti-starvation guard guarantees the debug reader progress.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 8, consecutive CPU grants with dbg pending before dbg is forced (guard only; legal range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, active-high
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU request accepted
cpu_rvalid  out  1  one-cycle pulse: CPU access complete
cpu_rdata  out  DW  CPU read data (write data echoed on writes)
dbg_req  in  1  debug read request (level)
dbg_addr  in  AW  debug address
dbg_gnt  out  1  one-cycle pulse: dbg request accepted
dbg_rvalid  out  1  one-cycle pulse: dbg read complete
dbg_rdata  out  DW  debug read data
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one clock after address
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. Everything is sampled on the rising edge of clk.
- Reset values: state = IDLE; all gnt, rvalid, mem_we and busy = 0; mem_addr, mem_wdata, cpu_rdata and dbg_rdata = 0; starvation counter = 0.
- FSM: IDLE -> ISSUE -> DATA -> IDLE. Each access takes 3 cycles, request to rvalid.
- IDLE:
  - Evaluate requests. CPU wins if cpu_req = 1; otherwise dbg wins if dbg_req = 1.
  - Latch the owner, address, we and wdata of the winner, then go to ISSUE. If neither requests, stay in IDLE.
- ISSUE:
  - Drive mem_addr and mem_wdata from the latched values.
  - mem_we = 1 for exactly this cycle, and only for a CPU write.
  - The owner's gnt = 1 for this cycle only.
  - Next state is DATA.
- DATA:
  - The owner's rvalid = 1.
  - The owner's rdata is loaded with mem_rdata on a read, or the latched wdata on a write, and holds until that owner's next completion.
  - Next state is IDLE.
- Handshake:
  - req must stay stable, with address and data stable, until gnt is seen.
  - The requester drops req in the cycle after gnt; a req still high in IDLE is a new request.
  - req is ignored during ISSUE and DATA.
- Request rules:
  - A dbg request always performs a read; there is no debug write path.
  - Simultaneous cpu_req and dbg_req in IDLE: CPU wins unless the guard (see Optional Feature) forces dbg.
- Mid-operation reset:
  - rst in ISSUE or DATA aborts the access: no further gnt/rvalid, and mem_we = 0 from the next cycle.
  - A write already in its ISSUE cycle is considered committed.
- Address handling: no internal address arithmetic. Addresses pass through unmodified; width truncation is the memory's concern.

Optional Feature:
- Macro: ARB_DBG_STARVE_EN.
- With the macro:
  - A counter increments on each CPU win taken in IDLE while dbg_req = 1.
  - The counter clears on any dbg win, or when dbg_req = 0 in IDLE.
  - When the counter equals STARVE_MAX, the next IDLE arbitration with dbg_req = 1 goes to dbg, then the counter clears.
  - The counter saturates and does not wrap.
- Without the macro: strict CPU priority, and no counter exists.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum {IDLE, ISSUE, DATA};
  - the owner encoding {OWN_CPU = 0, OWN_DBG = 1};
  - the default widths.
- One natural sub-module, arb_prio_pick: combinational winner select plus the starvation counter (the counter only when ARB_DBG_STARVE_EN is defined).

Test Plan:
- CPU read, mem[0x10] = 0x8C010004, cpu_req with addr 0x10 -> cpu_gnt at cycle 2, cpu_rvalid at cycle 3 with cpu_rdata = 0x8C010004; mem_we stays 0.
- CPU write of 0xDEADBEEF to 0x20 -> mem_we high for exactly one cycle with mem_addr = 0x20; cpu_rvalid follows with cpu_rdata = 0xDEADBEEF; a dbg read of 0x20 then returns 0xDEADBEEF.
- cpu_req and dbg_req raised in the same cycle -> CPU served first, then dbg: dbg_gnt 3 cycles after cpu_gnt.
- With ARB_DBG_STARVE_EN and STARVE_MAX = 8, cpu_req held continuously and dbg_req high -> exactly 8 CPU accesses, then 1 dbg access, repeating. Without the macro -> dbg is never granted.
- rst asserted during ISSUE of a dbg read -> no dbg_rvalid; state returns to IDLE, busy = 0 the next cycle, and all outputs hold reset values.
- Idle with no requests for 20 cycles -> busy, gnt, rvalid and mem_we all stay 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// rtl/mem_port_arbiter_prio_pick.sv - winner select with optional debug anti-starvation counter (ARB_DBG_STARVE_EN)
module arb_prio_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       cpu_req,
    input  logic       dbg_req,
    output logic       win_valid,
    output arb_owner_t win_owner
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

`ifdef ARB_DBG_STARVE_EN
    logic [7:0] starve_cnt;
    logic       force_dbg;

    assign force_dbg = dbg_req && (starve_cnt >= STARVE_LIM);

    // CPU has priority unless the debug reader has waited STARVE_MAX CPU wins
    always_comb begin
        win_valid = cpu_req | dbg_req;
        win_owner = OWN_CPU;
        if (force_dbg || (!cpu_req && dbg_req)) begin
            win_owner = OWN_DBG;
        end
    end

    // Count CPU wins taken over a waiting debug request; any dbg win or idle dbg clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (arb_en) begin
            if (!dbg_req || win_owner == OWN_DBG) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_pick_inputs;

    assign unused_pick_inputs = clk ^ rst ^ arb_en ^ (STARVE_LIM == 8'd0);

    // Strict CPU priority, no memory of past arbitrations
    always_comb begin
        win_valid = cpu_req | dbg_req;
        win_owner = OWN_CPU;
        if (!cpu_req && dbg_req) begin
            win_owner = OWN_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between CPU and debug reader (guard: ARB_DBG_STARVE_EN)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    arb_owner_t    owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;
    logic [DW-1:0] done_data;
    logic          arb_en;
    logic          win_valid;
    arb_owner_t    win_owner;

    assign arb_en    = (state_q == IDLE);
    assign done_data = we_q ? wdata_q : bus.mem_rdata;

    arb_prio_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .cpu_req   (bus.cpu_req),
        .dbg_req   (bus.dbg_req),
        .win_valid (win_valid),
        .win_owner (win_owner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every access walks IDLE -> ISSUE -> DATA -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_valid ? ISSUE : IDLE;
            ISSUE:   state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's request in IDLE; debug requests are always reads
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb_en && win_valid) begin
            owner_q <= win_owner;
            if (win_owner == OWN_CPU) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= bus.dbg_addr;
                wdata_q <= '0;
            end
        end
    end

    // Hold each requester's last completion data until its next completion
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (state_q == DATA) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= done_data;
            end else begin
                dbg_rdata_q <= done_data;
            end
        end
    end

    // Decode handshake pulses and memory strobes from the current state
    always_comb begin
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
        bus.mem_we     = (state_q == ISSUE) && we_q;
        bus.cpu_gnt    = (state_q == ISSUE) && (owner_q == OWN_CPU);
        bus.dbg_gnt    = (state_q == ISSUE) && (owner_q == OWN_DBG);
        bus.cpu_rvalid = (state_q == DATA) && (owner_q == OWN_CPU);
        bus.dbg_rvalid = (state_q == DATA) && (owner_q == OWN_DBG);
        bus.cpu_rdata  = bus.cpu_rvalid ? done_data : cpu_rdata_q;
        bus.dbg_rdata  = bus.dbg_rvalid ? done_data : dbg_rdata_q;
        busy           = (state_q != IDLE);
    end

endmodule
